mac_tx_frame_pack: RTL and testbench
====================================

// Module: mac_tx_frame_pack
// PURPOSE
// - Tx framer directly upstream of the MAC tx CRC stage. Accepts a per-frame command
//   (dest MAC, EtherType) plus a payload byte stream.
// - Emits a complete Ethernet frame without FCS on the MAC tx byte stream:
//   dst MAC, LOCAL_MAC, EtherType, payload, then zero pad to the minimum frame length.
// - Also enforces the maximum payload length.
// PARAMETERS
// - LOCAL_MAC    48'hABCD_1234_5678  source MAC inserted in every frame
// - MIN_FRAME    60                  min bytes out (hdr+payload+pad, FCS excluded)
// - MAX_PAYLOAD  1500                payload bytes forwarded per frame; excess dropped
// - VLAN_TCI     16'h0001            802.1Q TCI (only used with MAC_TX_VLAN_EN)
// PORTS
// - logic_clk       in   1   single clock for all logic
// - logic_rst       in   1   reset: synchronous, active-high
// - cmd_valid_in    in   1   frame command valid
// - cmd_ready_out   out  1   command accepted when valid&ready
// - cmd_dst_mac_in  in   48  destination MAC, byte [47:40] sent first
// - cmd_type_in     in   16  EtherType, byte [15:8] sent first
// - pay_tdata_in    in   8   payload byte
// - pay_tvalid_in   in   1   payload valid
// - pay_tready_out  out  1   payload ready
// - pay_tlast_in    in   1   last payload byte of frame
// - mac_tdata_out   out  8   frame byte to CRC stage
// - mac_tvalid_out  out  1   frame byte valid
// - mac_tready_in   in   1   CRC stage ready
// - mac_tlast_out   out  1   last byte of frame
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, counters 0; reset mid-frame abandons the frame.
// - Output register: loads when !mac_tvalid_out || mac_tready_in (adv). Data, valid
//   and last stay stable while valid && !ready.
// - Latency: 1 clk from accepted input byte to mac_tvalid_out.
// - IDLE: cmd_ready_out=1. On cmd handshake, latch dst/type, byte_cnt=0 -> HDR.
// - HDR: on adv, emit 14 header bytes from byte_cnt (dst[0..5], LOCAL_MAC[0..5], type[0..1])
//   -> PAY. pay_tready_out=0 in HDR.
// - PAY: pay_tready_out = adv. Each accepted byte is forwarded; pay_cnt++.
//   - On tlast: if total<MIN_FRAME -> PAD, else mac_tlast_out=1 -> IDLE.
//   - If pay_cnt reaches MAX_PAYLOAD without tlast: that byte gets mac_tlast_out=1 -> DROP.
// - PAD: on adv, emit 8'h00 until total==MIN_FRAME; last pad byte gets tlast -> IDLE.
// - DROP: pay_tready_out=1, no output; discard until pay_tlast_in accepted -> IDLE.
// - Payload is >=1 byte; tlast on 1st byte gives 15 data bytes + 45 pad bytes.
// - Counters: total 11 bits, pay 11 bits; never wrap (bounded by MAX_PAYLOAD+18).
// - New cmd is accepted only in IDLE. The cycle after the final tlast is accepted,
//   cmd_ready_out=1 (back-to-back frames, no bubble beyond 1 clk).
// CONFIGURATION
// - MAC_TX_VLAN_EN defined: insert 4-byte tag 8'h81,8'h00,VLAN_TCI[15:8],VLAN_TCI[7:0]
//   after src MAC.
//   - Header is 18 bytes; MIN_FRAME still counts all bytes, so min payload+pad is 42.
// - MAC_TX_VLAN_EN undefined: 14-byte header, no tag logic synthesised.
// STRUCTURE
// - Shared pkg mac_pkg: typedef enum {IDLE,HDR,PAY,PAD,DROP} tx_pack_state_t;
//   ETH_HDR_LEN=14, VLAN_TAG_LEN=4, ETH_MIN_FRAME=60, ETH_MAX_PAYLOAD=1500,
//   ETHERTYPE_VLAN=16'h8100.
// - Sub-module mac_tx_hdr_mux: combinational byte select from (byte_cnt, dst, type,
//   LOCAL_MAC, tag). The FSM and output register stay in the top.
// TESTING
// - cmd dst=FFFF_FFFF_FFFF type=16'h0806, 28B payload, tready=1 -> 60B out:
//   FF x6, AB CD 12 34 56 78, 08 06, 28 payload, 18x00; tlast on byte 60 only.
// - type=16'h0800, 100B payload 0..99 -> 114B, no pad, tlast on byte 114, cmd_ready the next clk.
// - Same frames, mac_tready_in random 50% -> byte stream identical to the tready=1 run;
//   data stable while stalled.
// - 1600B payload without early tlast, MAX_PAYLOAD=1500 -> 1514B out, tlast at 1514;
//   remaining 100B accepted and discarded.
// - Assert logic_rst at output byte 30, then a 46B frame -> outputs 0 the clk after rst;
//   next frame is a clean 60B, no pad.
// - MAC_TX_VLAN_EN, VLAN_TCI=16'h0064, 10B payload -> 81 00 00 64 after src MAC;
//   32 zero pad bytes; 60B total.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared MAC definitions: tx framer state type, Ethernet length constants.
// MAC_TX_VLAN_EN selects the 18-byte tagged header instead of the 14-byte one.
package mac_pkg;

    typedef enum logic [2:0] {IDLE, HDR, PAY, PAD, DROP} tx_pack_state_t;

    localparam int          ETH_HDR_LEN     = 14;
    localparam int          VLAN_TAG_LEN    = 4;
    localparam int          ETH_MIN_FRAME   = 60;
    localparam int          ETH_MAX_PAYLOAD = 1500;
    localparam logic [15:0] ETHERTYPE_VLAN  = 16'h8100;

`ifdef MAC_TX_VLAN_EN
    localparam int TX_HDR_LEN = ETH_HDR_LEN + VLAN_TAG_LEN;
`else
    localparam int TX_HDR_LEN = ETH_HDR_LEN;
`endif

endpackage

// File: rtl/mac_tx_hdr_mux.sv
// Combinational header byte select for the tx framer, byte 0 = first on the wire.
// MAC_TX_VLAN_EN inserts the 802.1Q tag between the source MAC and the EtherType.
module mac_tx_hdr_mux
    import mac_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC = 48'hABCD_1234_5678
`ifdef MAC_TX_VLAN_EN
    ,
    parameter logic [15:0] VLAN_TCI  = 16'h0001
`endif
) (
    input  logic [4:0]  byte_cnt,
    input  logic [47:0] dst,
    input  logic [15:0] eth_type,
    output logic [7:0]  hdr_byte
);

    localparam int HDR_BITS = TX_HDR_LEN * 8;

    logic [HDR_BITS-1:0] hdr;

`ifdef MAC_TX_VLAN_EN
    assign hdr = {dst, LOCAL_MAC, ETHERTYPE_VLAN, VLAN_TCI, eth_type};
`else
    assign hdr = {dst, LOCAL_MAC, eth_type};
`endif

    always_comb begin
        hdr_byte = 8'h00;
        for (int i = 0; i < TX_HDR_LEN; i++) begin
            if (byte_cnt == 5'(i)) begin
                hdr_byte = hdr[(TX_HDR_LEN-1-i)*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/mac_tx_frame_pack.sv
// Tx framer: header + payload + zero pad to MIN_FRAME, payload capped at MAX_PAYLOAD.
// Define MAC_TX_VLAN_EN to insert an 802.1Q tag (VLAN_TCI) after the source MAC.
module mac_tx_frame_pack
    import mac_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC   = 48'hABCD_1234_5678,
    parameter int          MIN_FRAME   = ETH_MIN_FRAME,
    parameter int          MAX_PAYLOAD = ETH_MAX_PAYLOAD
`ifdef MAC_TX_VLAN_EN
    ,
    parameter logic [15:0] VLAN_TCI    = 16'h0001
`endif
) (
    input  logic        logic_clk,
    input  logic        logic_rst,
    input  logic        cmd_valid_in,
    output logic        cmd_ready_out,
    input  logic [47:0] cmd_dst_mac_in,
    input  logic [15:0] cmd_type_in,
    input  logic [7:0]  pay_tdata_in,
    input  logic        pay_tvalid_in,
    output logic        pay_tready_out,
    input  logic        pay_tlast_in,
    output logic [7:0]  mac_tdata_out,
    output logic        mac_tvalid_out,
    input  logic        mac_tready_in,
    output logic        mac_tlast_out
);

    localparam logic [10:0] MIN_C    = 11'(MIN_FRAME);
    localparam logic [10:0] MAX_C    = 11'(MAX_PAYLOAD);
    localparam logic [4:0]  HDR_LAST = 5'(TX_HDR_LEN - 1);

    tx_pack_state_t state, next_state;

    logic [47:0] dst_q;
    logic [15:0] type_q;
    logic [4:0]  byte_cnt;
    logic [10:0] total_cnt;
    logic [10:0] pay_cnt;
    logic        adv;
    logic        pay_fire;
    logic        short_frame;
    logic        pay_full;
    logic        emit;
    logic        emit_last;
    logic [7:0]  emit_data;
    logic [7:0]  hdr_byte;

    assign adv         = !mac_tvalid_out || mac_tready_in;
    assign pay_fire    = pay_tvalid_in && pay_tready_out;
    assign short_frame = (total_cnt + 11'd1) < MIN_C;
    assign pay_full    = (pay_cnt + 11'd1) == MAX_C;

    mac_tx_hdr_mux #(
        .LOCAL_MAC (LOCAL_MAC)
`ifdef MAC_TX_VLAN_EN
        ,
        .VLAN_TCI  (VLAN_TCI)
`endif
    ) u_hdr_mux (
        .byte_cnt (byte_cnt),
        .dst      (dst_q),
        .eth_type (type_q),
        .hdr_byte (hdr_byte)
    );

    always_ff @(posedge logic_clk) begin
        if (logic_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: if (cmd_valid_in) next_state = HDR;
            HDR:  if (adv && byte_cnt == HDR_LAST) next_state = PAY;
            PAY: begin
                if (pay_fire) begin
                    if (pay_tlast_in) next_state = short_frame ? PAD : IDLE;
                    else if (pay_full) next_state = DROP;
                end
            end
            PAD:  if (adv && !short_frame) next_state = IDLE;
            DROP: if (pay_fire && pay_tlast_in) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // emit is only ever raised on a cycle where the output register advances.
    always_comb begin
        cmd_ready_out  = 1'b0;
        pay_tready_out = 1'b0;
        emit           = 1'b0;
        emit_last      = 1'b0;
        emit_data      = 8'h00;
        if (!logic_rst) begin
            unique case (state)
                IDLE: cmd_ready_out = 1'b1;
                HDR: begin
                    emit      = adv;
                    emit_data = hdr_byte;
                end
                PAY: begin
                    pay_tready_out = adv;
                    emit           = pay_fire;
                    emit_data      = pay_tdata_in;
                    emit_last      = pay_tlast_in ? !short_frame : pay_full;
                end
                PAD: begin
                    emit      = adv;
                    emit_last = !short_frame;
                end
                DROP: pay_tready_out = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge logic_clk) begin
        if (logic_rst) begin
            dst_q          <= '0;
            type_q         <= '0;
            byte_cnt       <= '0;
            total_cnt      <= '0;
            pay_cnt        <= '0;
            mac_tdata_out  <= '0;
            mac_tvalid_out <= 1'b0;
            mac_tlast_out  <= 1'b0;
        end else begin
            if (state == IDLE && cmd_valid_in) begin
                dst_q     <= cmd_dst_mac_in;
                type_q    <= cmd_type_in;
                byte_cnt  <= '0;
                total_cnt <= '0;
                pay_cnt   <= '0;
            end
            if (state == HDR && adv) byte_cnt <= byte_cnt + 5'd1;
            if (emit) total_cnt <= total_cnt + 11'd1;
            if (state == PAY && pay_fire) pay_cnt <= pay_cnt + 11'd1;
            if (adv) begin
                mac_tvalid_out <= emit;
                mac_tdata_out  <= emit_data;
                mac_tlast_out  <= emit_last;
            end
        end
    end

endmodule

// File: tb/tb_mac_tx_frame_pack.sv
// Self-checking bench for mac_tx_frame_pack against a byte-queue frame model.
// Works for both builds; the model adds the VLAN tag when MAC_TX_VLAN_EN is defined.
module tb_mac_tx_frame_pack;

    localparam logic [47:0] LOCAL_MAC   = 48'hABCD_1234_5678;
    localparam int          MIN_FRAME   = 60;
    localparam int          MAX_PAYLOAD = 1500;
    localparam logic [15:0] VLAN_TCI    = 16'h0001;

    logic        logic_clk = 1'b0;
    logic        logic_rst = 1'b1;
    logic        cmd_valid_in = 1'b0;
    logic        cmd_ready_out;
    logic [47:0] cmd_dst_mac_in = '0;
    logic [15:0] cmd_type_in = '0;
    logic [7:0]  pay_tdata_in = '0;
    logic        pay_tvalid_in = 1'b0;
    logic        pay_tready_out;
    logic        pay_tlast_in = 1'b0;
    logic [7:0]  mac_tdata_out;
    logic        mac_tvalid_out;
    logic        mac_tready_in = 1'b1;
    logic        mac_tlast_out;

    int checks = 0;
    int errors = 0;
    int stall_err = 0;
    bit rand_ready = 1'b0;
    bit rand_gap = 1'b0;

    logic [7:0] pay_q[$];
    logic [7:0] exp_data[$];
    bit         exp_last[$];
    logic [7:0] rx_data[$];
    bit         rx_last[$];

    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    logic       prev_last = 1'b0;

    always #5 logic_clk = ~logic_clk;

    mac_tx_frame_pack dut (
        .logic_clk      (logic_clk),
        .logic_rst      (logic_rst),
        .cmd_valid_in   (cmd_valid_in),
        .cmd_ready_out  (cmd_ready_out),
        .cmd_dst_mac_in (cmd_dst_mac_in),
        .cmd_type_in    (cmd_type_in),
        .pay_tdata_in   (pay_tdata_in),
        .pay_tvalid_in  (pay_tvalid_in),
        .pay_tready_out (pay_tready_out),
        .pay_tlast_in   (pay_tlast_in),
        .mac_tdata_out  (mac_tdata_out),
        .mac_tvalid_out (mac_tvalid_out),
        .mac_tready_in  (mac_tready_in),
        .mac_tlast_out  (mac_tlast_out)
    );

    // Sink ready: always 1, or a fair coin per cycle when rand_ready is set.
    initial begin
        forever begin
            @(posedge logic_clk);
            #1;
            mac_tready_in = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Collect accepted bytes and flag any change while the sink is stalling.
    always @(negedge logic_clk) begin
        if (logic_rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && (!mac_tvalid_out || mac_tdata_out !== prev_data ||
                               mac_tlast_out !== prev_last))
                stall_err <= stall_err + 1;
            if (mac_tvalid_out && mac_tready_in) begin
                rx_data.push_back(mac_tdata_out);
                rx_last.push_back(mac_tlast_out);
            end
            prev_stall <= mac_tvalid_out && !mac_tready_in;
            prev_data  <= mac_tdata_out;
            prev_last  <= mac_tlast_out;
        end
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic fill_payload(input int n, input bit incr);
        pay_q.delete();
        for (int i = 0; i < n; i++)
            pay_q.push_back(incr ? 8'(i) : 8'($urandom_range(0, 255)));
    endtask

    // Expected wire image: dst, src, [tag], type, capped payload, zero pad to MIN_FRAME.
    task automatic build_expected(input logic [47:0] dst, input logic [15:0] etype);
        logic [47:0] src;
        int n;
        src = LOCAL_MAC;
        exp_data.delete();
        exp_last.delete();
        for (int k = 0; k < 6; k++) exp_data.push_back(dst[47-8*k -: 8]);
        for (int k = 0; k < 6; k++) exp_data.push_back(src[47-8*k -: 8]);
`ifdef MAC_TX_VLAN_EN
        exp_data.push_back(8'h81);
        exp_data.push_back(8'h00);
        exp_data.push_back(VLAN_TCI[15:8]);
        exp_data.push_back(VLAN_TCI[7:0]);
`endif
        exp_data.push_back(etype[15:8]);
        exp_data.push_back(etype[7:0]);
        n = (pay_q.size() > MAX_PAYLOAD) ? MAX_PAYLOAD : pay_q.size();
        for (int i = 0; i < n; i++) exp_data.push_back(pay_q[i]);
        while (exp_data.size() < MIN_FRAME) exp_data.push_back(8'h00);
        for (int i = 0; i < exp_data.size(); i++) exp_last.push_back(i == exp_data.size() - 1);
    endtask

    task automatic send_cmd(input logic [47:0] dst, input logic [15:0] etype, output bit ok);
        bit fire;
        ok = 1'b0;
        cmd_dst_mac_in = dst;
        cmd_type_in    = etype;
        cmd_valid_in   = 1'b1;
        for (int g = 0; g < 200 && !ok; g++) begin
            @(negedge logic_clk);
            fire = cmd_ready_out;
            @(posedge logic_clk);
            #1;
            ok = fire;
        end
        cmd_valid_in = 1'b0;
    endtask

    task automatic send_payload(input int stop_rx, output bit ok);
        int i;
        int guard;
        bit fire;
        i = 0;
        guard = 0;
        ok = 1'b1;
        while (i < pay_q.size()) begin
            if (stop_rx > 0 && rx_data.size() >= stop_rx) break;
            if (guard > 20000) begin
                ok = 1'b0;
                break;
            end
            pay_tvalid_in = !(rand_gap && $urandom_range(0, 3) == 0);
            pay_tdata_in  = pay_q[i];
            pay_tlast_in  = (i == pay_q.size() - 1);
            @(negedge logic_clk);
            fire = pay_tvalid_in && pay_tready_out;
            @(posedge logic_clk);
            #1;
            if (fire) i++;
            guard++;
        end
        pay_tvalid_in = 1'b0;
        pay_tlast_in  = 1'b0;
    endtask

    task automatic compare_frame(input string tag);
        int n;
        int bad;
        int bad_last;
        int guard;
        guard = 0;
        while (rx_data.size() < exp_data.size() && guard < 4000) begin
            @(posedge logic_clk);
            guard++;
        end
        check_output({tag, "_drain_timeout"}, int'(guard >= 4000), 0);
        repeat (4) @(posedge logic_clk);
        #1;
        n = (rx_data.size() < exp_data.size()) ? rx_data.size() : exp_data.size();
        bad = 0;
        bad_last = 0;
        for (int i = 0; i < n; i++) begin
            if (rx_data[i] !== exp_data[i]) bad++;
            if (rx_last[i] !== exp_last[i]) bad_last++;
        end
        check_output({tag, "_len"}, rx_data.size(), exp_data.size());
        check_output({tag, "_bad_bytes"}, bad, 0);
        check_output({tag, "_bad_tlast"}, bad_last, 0);
        check_output({tag, "_stall_changes"}, stall_err, 0);
    endtask

    task automatic apply_stimulus(input string tag, input logic [47:0] dst,
                                  input logic [15:0] etype, input int n, input bit incr,
                                  input bit keep, input bit check_b2b);
        bit ok;
        if (!keep) fill_payload(n, incr);
        build_expected(dst, etype);
        rx_data.delete();
        rx_last.delete();
        stall_err = 0;
        send_cmd(dst, etype, ok);
        check_output({tag, "_cmd_accepted"}, int'(ok), 1);
        send_payload(0, ok);
        check_output({tag, "_payload_accepted"}, int'(ok), 1);
        if (check_b2b) check_output({tag, "_cmd_ready_next"}, int'(cmd_ready_out), 1);
        compare_frame(tag);
    endtask

    initial begin
        bit ok;
        logic [47:0] rdst;
        logic [15:0] rtype;

        logic_rst = 1'b1;
        repeat (3) @(posedge logic_clk);
        #1;
        check_output("rst_tvalid", int'(mac_tvalid_out), 0);
        check_output("rst_tlast", int'(mac_tlast_out), 0);
        check_output("rst_tdata", int'(mac_tdata_out), 0);
        check_output("rst_cmd_ready", int'(cmd_ready_out), 0);
        check_output("rst_pay_ready", int'(pay_tready_out), 0);
        logic_rst = 1'b0;
        @(negedge logic_clk);
        check_output("idle_cmd_ready", int'(cmd_ready_out), 1);
        check_output("idle_pay_ready", int'(pay_tready_out), 0);
        @(posedge logic_clk);
        #1;

        rand_ready = 1'b0;
        apply_stimulus("arp28", 48'hFFFF_FFFF_FFFF, 16'h0806, 28, 1'b0, 1'b0, 1'b0);
        rand_ready = 1'b1;
        apply_stimulus("arp28_stall", 48'hFFFF_FFFF_FFFF, 16'h0806, 28, 1'b0, 1'b1, 1'b0);
        rand_ready = 1'b0;
        apply_stimulus("ip100", 48'h0011_2233_4455, 16'h0800, 100, 1'b1, 1'b0, 1'b1);
        rand_ready = 1'b1;
        apply_stimulus("ip100_stall", 48'h0011_2233_4455, 16'h0800, 100, 1'b1, 1'b1, 1'b1);
        rand_ready = 1'b0;
        apply_stimulus("one_byte", 48'h0200_0000_0001, 16'h88B5, 1, 1'b0, 1'b0, 1'b0);
        apply_stimulus("pay45", 48'h0200_0000_0002, 16'h88B5, 45, 1'b0, 1'b0, 1'b0);
        apply_stimulus("oversize", 48'h0200_0000_0003, 16'h0800, 1600, 1'b0, 1'b0, 1'b1);

        // Reset while the 30th output byte is leaving, then a clean 46-byte frame.
        fill_payload(46, 1'b0);
        rx_data.delete();
        rx_last.delete();
        send_cmd(48'h0200_0000_0004, 16'h0800, ok);
        check_output("midrst_cmd_accepted", int'(ok), 1);
        send_payload(30, ok);
        check_output("midrst_reached_byte30", int'(rx_data.size() >= 30), 1);
        logic_rst = 1'b1;
        @(posedge logic_clk);
        #1;
        check_output("midrst_tvalid", int'(mac_tvalid_out), 0);
        check_output("midrst_tlast", int'(mac_tlast_out), 0);
        check_output("midrst_tdata", int'(mac_tdata_out), 0);
        logic_rst = 1'b0;
        @(posedge logic_clk);
        #1;
        apply_stimulus("post_rst46", 48'h0200_0000_0005, 16'h0800, 46, 1'b0, 1'b0, 1'b0);

        rand_ready = 1'b1;
        rand_gap   = 1'b1;
        for (int f = 0; f < 6; f++) begin
            rdst  = {$urandom(), 16'($urandom())};
            rtype = 16'($urandom());
            apply_stimulus($sformatf("rand%0d", f), rdst, rtype, $urandom_range(1, 120),
                           1'b0, 1'b0, 1'b0);
        end
        rand_ready = 1'b0;
        rand_gap   = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
